// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// Module      : game_pkg
// Description : Shared coordinate, bolt-slot and colour definitions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic   active;
    coord_t x;
    coord_t y;
  } bolt_slot_t;

  localparam logic [7:0] c_RGB_BLACK  = 8'h00;
  localparam logic [7:0] c_RGB_YELLOW = 8'hFC;

  localparam int c_BOLT_MAX_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/bolt_hit_test.sv
//------------------------------------------------------------------------------
// Module      : bolt_hit_test
// Description : Combinational rectangle test of one bolt slot against the scan pixel.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bolt_hit_test
  import game_pkg::*;
#(
  parameter int BOLT_W = 2,
  parameter int BOLT_H = 8
) (
  input  bolt_slot_t slot,
  input  coord_t     pixelX,
  input  coord_t     pixelY,
  output logic       hit
);

  coord_t w_dx;
  coord_t w_dy;

  // Unsigned wrap makes a pixel left of / above the bolt look huge, so it fails.
  always_comb begin
    w_dx = pixelX - slot.x;
    w_dy = pixelY - slot.y;
    hit  = slot.active && (w_dx < coord_t'(BOLT_W)) && (w_dy < coord_t'(BOLT_H));
  end

endmodule

`default_nettype wire

// File: rtl/player_bolts_drawer.sv
//------------------------------------------------------------------------------
// Module      : player_bolts_drawer
// Description : Spawns, moves, retires and renders the player's bolts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module player_bolts_drawer
  import game_pkg::*;
#(
  parameter int         BOLT_MAX   = c_BOLT_MAX_DEFAULT,
  parameter int         BOLT_W     = 2,
  parameter int         BOLT_H     = 8,
  parameter int         SPEED      = 4,
  parameter int         PLR_W      = 32,
  parameter int         COOLDOWN   = 10,
  parameter logic [7:0] BOLT_COLOR = c_RGB_YELLOW
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fireReq,
  input  coord_t     playerX,
  input  coord_t     playerY,
  input  coord_t     pixelX,
  input  coord_t     pixelY,
  input  logic       boltHit,
  output logic       btpReq,
  output logic [7:0] btpRGB,
  output logic [3:0] boltsActive
);

  localparam int     c_SLOT_W   = (BOLT_MAX > 1) ? $clog2(BOLT_MAX) : 1;
  localparam int     c_CD_W     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam coord_t c_SPAWN_DX = coord_t'(PLR_W / 2 - BOLT_W / 2);
  localparam coord_t c_SPEED    = coord_t'(SPEED);
  localparam coord_t c_BOLT_H   = coord_t'(BOLT_H);
  localparam logic [c_CD_W-1:0] c_COOLDOWN = c_CD_W'(COOLDOWN);

  bolt_slot_t            r_slots     [BOLT_MAX];
  bolt_slot_t            w_slots_nxt [BOLT_MAX];
  logic                  r_pending;
  logic                  w_pending_nxt;
  logic                  w_pend_in;
  logic [c_CD_W-1:0]     r_cooldown;
  logic [c_CD_W-1:0]     w_cooldown_nxt;
  logic [c_SLOT_W-1:0]   r_hitSlot;
  logic                  r_btpReq;
  logic [7:0]            r_btpRGB;
  logic [3:0]            r_boltsActive;
  logic                  w_spawned;
  logic                  w_free_found;
  logic [c_SLOT_W-1:0]   w_free_idx;
  coord_t                w_spawn_y;
  logic [BOLT_MAX-1:0]   w_hits;
  logic                  w_any_hit;
  logic [c_SLOT_W-1:0]   w_win_idx;
  logic [3:0]            w_count;

  // Slot update: kill, then move/retire, then spawn into the lowest free slot.
  always_comb begin
    w_slots_nxt    = r_slots;
    w_pend_in      = r_pending | (fireReq && (r_cooldown == '0));
    w_pending_nxt  = w_pend_in;
    w_cooldown_nxt = r_cooldown;
    w_spawned      = 1'b0;
    w_free_found   = 1'b0;
    w_free_idx     = '0;
    w_spawn_y      = (playerY >= c_BOLT_H) ? (playerY - c_BOLT_H) : '0;

    if (boltHit && r_btpReq) begin
      w_slots_nxt[r_hitSlot].active = 1'b0;
    end

    if (startOfFrame) begin
      for (int i = 0; i < BOLT_MAX; i++) begin
        if (w_slots_nxt[i].active) begin
          if (w_slots_nxt[i].y >= c_SPEED) begin
            w_slots_nxt[i].y = w_slots_nxt[i].y - c_SPEED;
          end else begin
            w_slots_nxt[i].active = 1'b0;
          end
        end
      end

      for (int i = BOLT_MAX - 1; i >= 0; i--) begin
        if (!w_slots_nxt[i].active) begin
          w_free_found = 1'b1;
          w_free_idx   = c_SLOT_W'(i);
        end
      end

      if (w_pend_in) begin
        w_pending_nxt = 1'b0;
        if (w_free_found) begin
          w_slots_nxt[w_free_idx].active = 1'b1;
          w_slots_nxt[w_free_idx].x      = playerX + c_SPAWN_DX;
          w_slots_nxt[w_free_idx].y      = w_spawn_y;
          w_cooldown_nxt                 = c_COOLDOWN;
          w_spawned                      = 1'b1;
        end
      end

      if (!w_spawned && (r_cooldown != '0)) begin
        w_cooldown_nxt = r_cooldown - 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < BOLT_MAX; g++) begin : g_hit
      bolt_hit_test #(
        .BOLT_W (BOLT_W),
        .BOLT_H (BOLT_H)
      ) u_hit (
        .slot   (r_slots[g]),
        .pixelX (pixelX),
        .pixelY (pixelY),
        .hit    (w_hits[g])
      );
    end
  endgenerate

  always_comb begin
    w_any_hit = |w_hits;
    w_win_idx = '0;
    for (int i = BOLT_MAX - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_win_idx = c_SLOT_W'(i);
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < BOLT_MAX; i++) begin
      if (r_slots[i].active) begin
        w_count = w_count + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < BOLT_MAX; i++) begin
        r_slots[i] <= '0;
      end
      r_pending     <= 1'b0;
      r_cooldown    <= '0;
      r_hitSlot     <= '0;
      r_btpReq      <= 1'b0;
      r_btpRGB      <= c_RGB_BLACK;
      r_boltsActive <= '0;
    end else begin
      for (int i = 0; i < BOLT_MAX; i++) begin
        r_slots[i] <= w_slots_nxt[i];
      end
      r_pending     <= w_pending_nxt;
      r_cooldown    <= w_cooldown_nxt;
      r_hitSlot     <= w_win_idx;
      r_btpReq      <= w_any_hit;
      r_btpRGB      <= w_any_hit ? BOLT_COLOR : c_RGB_BLACK;
      r_boltsActive <= w_count;
    end
  end

  assign btpReq      = r_btpReq;
  assign btpRGB      = r_btpRGB;
  assign boltsActive = r_boltsActive;

endmodule

`default_nettype wire

// File: tb/tb_player_bolts_drawer.sv
//------------------------------------------------------------------------------
// Module      : tb_player_bolts_drawer
// Description : Directed self-checking bench for player_bolts_drawer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_player_bolts_drawer;
  import game_pkg::*;

  localparam coord_t c_IDLE = 11'd2047;

  logic       clk          = 1'b0;
  logic       resetN       = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       fireReq      = 1'b0;
  logic       boltHit      = 1'b0;
  coord_t     playerX      = '0;
  coord_t     playerY      = '0;
  coord_t     pixelX       = c_IDLE;
  coord_t     pixelY       = c_IDLE;
  logic       btpReq;
  logic [7:0] btpRGB;
  logic [3:0] boltsActive;

  int checks = 0;
  int errors = 0;
  int f      = -1;

  always #5 clk = ~clk;

  player_bolts_drawer dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fireReq      (fireReq),
    .playerX      (playerX),
    .playerY      (playerY),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .boltHit      (boltHit),
    .btpReq       (btpReq),
    .btpRGB       (btpRGB),
    .boltsActive  (boltsActive)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    f++;
    tick();
  endtask

  task automatic frames_to(input int target);
    while (f < target) frame();
  endtask

  task automatic fire(input coord_t x, input coord_t y);
    playerX = x;
    playerY = y;
    fireReq = 1'b1;
    tick();
    fireReq = 1'b0;
    tick();
  endtask

  task automatic probe(input string tag, input coord_t x, input coord_t y, input logic exp);
    pixelX = x;
    pixelY = y;
    tick();
    chk({tag, "_req"}, {31'd0, btpReq}, {31'd0, exp});
    chk({tag, "_rgb"}, {24'd0, btpRGB}, exp ? 32'hFC : 32'h00);
    pixelX = c_IDLE;
    pixelY = c_IDLE;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    resetN = 1'b1;
    chk("rst_req", {31'd0, btpReq}, 32'd0);
    chk("rst_rgb", {24'd0, btpRGB}, 32'd0);
    chk("rst_active", {28'd0, boltsActive}, 32'd0);

    // First shot: slot0 at (115,392)
    fire(11'd100, 11'd400);
    frame();
    chk("shot1_active", {28'd0, boltsActive}, 32'd1);
    probe("s0_origin", 11'd115, 11'd392, 1'b1);
    probe("s0_right_edge", 11'd116, 11'd399, 1'b1);
    probe("s0_past_right", 11'd117, 11'd392, 1'b0);
    probe("s0_left_of", 11'd114, 11'd392, 1'b0);
    probe("s0_below", 11'd115, 11'd400, 1'b0);
    frame();
    probe("s0_moved", 11'd115, 11'd388, 1'b1);
    probe("s0_moved_x2", 11'd117, 11'd388, 1'b0);
    probe("s0_old_top", 11'd115, 11'd387, 1'b0);

    // Fire during cooldown is ignored
    fire(11'd200, 11'd400);
    frames_to(9);
    fire(11'd200, 11'd400);
    frames_to(10);
    chk("cooldown_ignore", {28'd0, boltsActive}, 32'd1);

    // Two pulses collapse into one shot, accepted once cooldown expired
    fire(11'd200, 11'd400);
    fire(11'd200, 11'd400);
    frames_to(11);
    chk("shot2_active", {28'd0, boltsActive}, 32'd2);
    probe("s1_origin", 11'd215, 11'd392, 1'b1);
    probe("s0_f11", 11'd115, 11'd348, 1'b1);

    frames_to(21);
    fire(11'd300, 11'd400);
    frames_to(22);
    chk("shot3_active", {28'd0, boltsActive}, 32'd3);
    frames_to(32);
    fire(11'd400, 11'd400);
    frames_to(33);
    chk("shot4_active", {28'd0, boltsActive}, 32'd4);
    frames_to(43);
    fire(11'd500, 11'd400);
    frames_to(44);
    chk("shot5_lost_active", {28'd0, boltsActive}, 32'd4);
    probe("shot5_lost_pix", 11'd515, 11'd392, 1'b0);

    // boltHit without btpReq is ignored
    boltHit = 1'b1;
    tick();
    boltHit = 1'b0;
    tick();
    chk("hit_ignored", {28'd0, boltsActive}, 32'd4);

    // Hit slot1 at (215,260)
    pixelX = 11'd215;
    pixelY = 11'd260;
    tick();
    chk("hit_s1_req", {31'd0, btpReq}, 32'd1);
    pixelX = c_IDLE;
    pixelY = c_IDLE;
    boltHit = 1'b1;
    tick();
    boltHit = 1'b0;
    tick();
    chk("hit_s1_active", {28'd0, boltsActive}, 32'd3);
    probe("s1_dead", 11'd215, 11'd260, 1'b0);
    probe("s0_alive", 11'd115, 11'd216, 1'b1);
    probe("s2_alive", 11'd315, 11'd304, 1'b1);
    frames_to(45);
    probe("s0_f45", 11'd115, 11'd212, 1'b1);
    probe("s0_f45_below", 11'd115, 11'd220, 1'b0);
    probe("s2_f45", 11'd315, 11'd300, 1'b1);
    probe("s1_f45_dead", 11'd215, 11'd256, 1'b0);

    // Hit coincident with startOfFrame; pending shot reuses slot0
    fire(11'd600, 11'd400);
    pixelX = 11'd115;
    pixelY = 11'd212;
    tick();
    chk("sofhit_req", {31'd0, btpReq}, 32'd1);
    pixelX = c_IDLE;
    pixelY = c_IDLE;
    boltHit = 1'b1;
    startOfFrame = 1'b1;
    tick();
    boltHit = 1'b0;
    startOfFrame = 1'b0;
    f++;
    tick();
    chk("sofhit_active", {28'd0, boltsActive}, 32'd3);
    probe("reuse_spawn", 11'd615, 11'd392, 1'b1);
    probe("killed_not_moved", 11'd115, 11'd208, 1'b0);
    probe("killed_gone", 11'd115, 11'd212, 1'b0);
    probe("s2_f46", 11'd315, 11'd296, 1'b1);

    frames_to(56);
    fire(11'd700, 11'd400);
    frames_to(57);
    chk("refill_active", {28'd0, boltsActive}, 32'd4);

    // Retirement at the top: slot2 spawned at f=22 reaches y=0 at f=120
    frames_to(120);
    chk("pre_retire_active", {28'd0, boltsActive}, 32'd4);
    probe("s2_at_top", 11'd315, 11'd0, 1'b1);
    frames_to(121);
    chk("retire_active", {28'd0, boltsActive}, 32'd3);
    probe("s2_retired", 11'd315, 11'd0, 1'b0);
    probe("s2_no_wrap", 11'd315, 11'd2044, 1'b0);

    // Asynchronous reset mid-frame with 3 live bolts
    pixelX = 11'd415;
    pixelY = 11'd40;
    tick();
    chk("pre_reset_req", {31'd0, btpReq}, 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, btpReq}, 32'd0);
    chk("async_rst_rgb", {24'd0, btpRGB}, 32'd0);
    chk("async_rst_active", {28'd0, boltsActive}, 32'd0);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    chk("post_rst_req", {31'd0, btpReq}, 32'd0);
    pixelX = c_IDLE;
    pixelY = c_IDLE;
    frame();
    chk("post_rst_active", {28'd0, boltsActive}, 32'd0);
    probe("post_rst_s3", 11'd415, 11'd36, 1'b0);
    probe("post_rst_s0", 11'd615, 11'd92, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/player_bolts_drawer.md
Name: player_bolts_drawer

Overview:
- Manages up to BOLT_MAX player bolts in flight: spawns them on fire requests, moves them up once per frame, retires them at the screen top or on collision.
- Renders all live bolts as one pixel stream, btpReq/btpRGB, which feeds the objects mux's player-bolt input.
- Sits between the game/keyboard logic and the objects mux, on the VGA pixel timeline.

Parameters:
- BOLT_MAX, 4, number of bolt slots (1..8)
- BOLT_W, 2, bolt width in pixels
- BOLT_H, 8, bolt height in pixels
- SPEED, 4, pixels moved up per frame
- PLR_W, 32, player sprite width, used to centre the spawn point
- COOLDOWN, 10, minimum frames between two accepted shots
- BOLT_COLOR, 8'hFC, RGB332 colour of a bolt

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start (vertical blank)
- fireReq  in  1  fire pulse from the key decoder; may arrive at any cycle
- playerX  in  11  player top-left X
- playerY  in  11  player top-left Y
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- boltHit  in  1  collision pulse, valid in the same cycle as btpReq
- btpReq  out  1  drawing request for a bolt pixel
- btpRGB  out  8  bolt colour
- boltsActive  out  4  number of live slots (status/debug)

Behaviour:
- Reset: all slots inactive, pending = 0, cooldown = 0, hitSlot = 0, btpReq = 0, btpRGB = 0, boltsActive = 0. Reset mid-frame kills every bolt immediately.
- Slot state: active bit, x[10:0], y[10:0] per slot.
- Fire capture:
  - fireReq sets pending whenever cooldown == 0.
  - Pulses while cooldown != 0 are ignored.
  - Multiple pulses within one frame collapse into a single shot.
- On startOfFrame, in this order:
  1. Kill: a slot killed by boltHit in this same cycle stays dead and is not moved.
  2. Move: each active slot with y >= SPEED gets y -= SPEED. If y < SPEED, the slot is deactivated (retired at top, no wrap-around).
  3. Spawn: if pending, take the lowest-index free slot (after steps 1–2). Set x = playerX + PLR_W/2 - BOLT_W/2 and y = playerY - BOLT_H, saturated at 0. Clear pending and load cooldown = COOLDOWN.
  4. Full slots: if pending and no slot is free, clear pending (shot lost) and leave cooldown unchanged.
  5. Cooldown: if cooldown != 0 and no spawn occurred this frame, decrement by 1.
- Drawing, combinational hit test per slot: active && pixelX - x < BOLT_W && pixelY - y < BOLT_H, computed as unsigned 11-bit subtraction so a negative difference fails. The lowest-index hitting slot wins.
- Output register, fixed latency of 1 clock:
  - btpReq(n+1) = any hit at (pixelX, pixelY)(n).
  - btpRGB = BOLT_COLOR when btpReq is 1, else 0.
  - hitSlot <= index of the winning slot.
- Collision: boltHit is sampled only when btpReq = 1; it deactivates slot hitSlot at the next edge. boltHit with btpReq = 0 is ignored. Several hits within one frame are allowed.
- boltsActive: registered popcount of active bits, updated one cycle after any change.
- Arithmetic: all coordinates 11-bit unsigned. Spawn-X addition wraps modulo 2^11; the game logic guarantees playerX keeps the result on screen.

Decomposition:
- Shared package game_pkg:
  - coordinate typedef coord_t (logic [10:0])
  - bolt_slot_t struct {active, x, y}
  - RGB332 colour constants
  - BOLT_MAX default
- One sub-module, bolt_hit_test: combinational rectangle test of one slot against (pixelX, pixelY). Instantiated BOLT_MAX times in a generate loop; its outputs feed a priority encoder.

Test Plan:
- Reset, then one fireReq with playerX = 100, playerY = 400 -> after the next startOfFrame, slot0 at (115, 392). The following frame at pixel (115, 388) -> btpReq = 1 and btpRGB = 8'hFC one clock later; at pixel (117, 388) -> btpReq = 0.
- Fire every COOLDOWN frames, 5 times, with no hits -> boltsActive reaches 4 and the 5th shot is lost. A bolt spawned at y = 392 retires after 99 frames (y = 0 < SPEED), after which boltsActive decrements.
- Two fireReq pulses within COOLDOWN frames -> only the first spawns. A pulse at frame 10 after the shot is accepted.
- boltHit asserted in the same cycle as btpReq for slot1 while slots 0 and 2 are live -> slot1 inactive next cycle, boltsActive drops by 1, slots 0 and 2 keep moving.
- boltHit coincident with startOfFrame for the drawn slot -> that slot is not moved and is dead. A pending shot may reuse that slot in the same frame.
- Assert resetN low mid-frame with 3 live bolts -> btpReq = 0 and boltsActive = 0 immediately (asynchronous), and no bolts remain after release.
